fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - two-requester framebuffer write arbiter with optional full-frame clear engine
// Optional clear engine is compiled in when FB_CLEAR_EN is defined.
module fb_write_arbiter #(
    parameter int FB_WORDS = 307200,
    parameter int AW       = 19,
    parameter int DW       = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic          fb_wen,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_din,
    output logic [7:0]    drop_count
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [AW:0]   LP_WORDS = (AW+1)'(FB_WORDS);
    localparam logic [AW-1:0] LP_LAST  = AW'(FB_WORDS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_clr_color;

    logic          w_clear_go;
    logic          w_clear_wr;
    logic          w_grant0;
    logic          w_grant1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_in_range;

    always_comb begin
        w_next_state = r_state;
        w_clear_go   = 1'b0;
        w_clear_wr   = 1'b0;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
`ifdef FB_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            w_clear_wr = 1'b1;
            if (r_clr_cnt == LP_LAST) begin
                w_next_state = ST_IDLE;
            end
        end else if (clear_start) begin
            w_clear_go   = 1'b1;
            w_next_state = ST_CLEAR;
        end
`endif
        // Clear start pre-empts any pending request in the same cycle.
        if (r_state == ST_IDLE && !w_clear_go && reset_n) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_addr     = w_grant1 ? req1_addr : req0_addr;
    assign w_data     = w_grant1 ? req1_data : req0_data;
    assign w_in_range = {1'b0, w_addr} < LP_WORDS;

`ifdef FB_CLEAR_EN
    assign clear_busy = (r_state == ST_CLEAR);
`else
    logic w_unused_clear;
    assign w_unused_clear = clear_start;
    assign clear_busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_clr_cnt    <= '0;
            r_clr_color  <= '0;
            fb_wen       <= 1'b0;
            fb_addr      <= '0;
            fb_din       <= '0;
            drop_count   <= '0;
        end else begin
            r_state <= w_next_state;
            fb_wen  <= 1'b0;
            if (w_clear_go) begin
                r_clr_color <= clear_color;
                r_clr_cnt   <= '0;
            end
            if (w_clear_wr) begin
                fb_wen  <= 1'b1;
                fb_addr <= r_clr_cnt;
                fb_din  <= r_clr_color;
                if (r_clr_cnt != LP_LAST) begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end else if (w_grant0 || w_grant1) begin
                r_last_grant <= w_grant1;
                // Out-of-range writes are handshaken but never reach the RAM.
                if (w_in_range) begin
                    fb_wen  <= 1'b1;
                    fb_addr <= w_addr;
                    fb_din  <= w_data;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

    localparam int FBW = 2048;
    localparam int AW  = 19;
    localparam int DW  = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, fb_addr;
    logic [DW-1:0] req0_data, req1_data, clear_color, fb_din;
    logic          clear_start, clear_busy, fb_wen;
    logic [7:0]    drop_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.FB_WORDS(FBW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_din(fb_din), .drop_count(drop_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        req0_valid  = 1'b1; req0_addr = '0; req0_data = '0;
        req1_valid  = 1'b0; req1_addr = '0; req1_data = '0;
        clear_start = 1'b0; clear_color = '0;
        #2;
        check_eq("rst_ready0", req0_ready, 0);
        check_eq("rst_ready1", req1_ready, 0);
        check_eq("rst_wen", fb_wen, 0);
        check_eq("rst_addr", fb_addr, 0);
        check_eq("rst_din", fb_din, 0);
        check_eq("rst_busy", clear_busy, 0);
        check_eq("rst_drop", drop_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);

        // Contention straight after reset: req0 first, then alternate.
        req0_valid = 1'b1; req0_addr = 19'd10; req0_data = 6'h01;
        req1_valid = 1'b1; req1_addr = 19'd20; req1_data = 6'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("rr_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            @(negedge clk);
            check_eq($sformatf("rr_wen_%0d", i), fb_wen, 1);
            check_eq($sformatf("rr_addr_%0d", i), fb_addr, (i % 2 == 0) ? 10 : 20);
            check_eq($sformatf("rr_din_%0d", i), fb_din, (i % 2 == 0) ? 1 : 2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Single requester write.
        req0_valid = 1'b1; req0_addr = 19'd100; req0_data = 6'h3F;
        #1;
        check_eq("single_ready0", req0_ready, 1);
        check_eq("single_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        check_eq("single_wen", fb_wen, 1);
        check_eq("single_addr", fb_addr, 100);
        check_eq("single_din", fb_din, 6'h3F);
        #1;
        check_eq("idle_ready0", req0_ready, 0);
        @(negedge clk);
        check_eq("idle_wen", fb_wen, 0);
        check_eq("idle_addr_hold", fb_addr, 100);
        check_eq("idle_din_hold", fb_din, 6'h3F);

        // Out-of-range write is accepted but dropped.
        req1_valid = 1'b1; req1_addr = 19'd307200; req1_data = 6'h05;
        #1;
        check_eq("drop_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        check_eq("drop_wen", fb_wen, 0);
        check_eq("drop_addr_hold", fb_addr, 100);
        check_eq("drop_cnt1", drop_count, 1);

        req1_valid = 1'b1; req1_addr = 19'(FBW - 1); req1_data = 6'h07;
        @(negedge clk);
        check_eq("last_wen", fb_wen, 1);
        check_eq("last_addr", fb_addr, FBW - 1);
        check_eq("last_drop", drop_count, 1);
        req1_addr = 19'(FBW);
        @(negedge clk);
        check_eq("edge_wen", fb_wen, 0);
        check_eq("edge_drop", drop_count, 2);

        req1_addr = 19'd307200;
        repeat (300) @(negedge clk);
        req1_valid = 1'b0;
        check_eq("drop_sat", drop_count, 255);
        @(negedge clk);
        check_eq("drop_sat_hold", drop_count, 255);

`ifdef FB_CLEAR_EN
        begin
            int nwr;
            int bad;
            int first_addr;
            bit found;
            nwr = 0; bad = 0; first_addr = -1; found = 0;
            req0_valid  = 1'b1; req0_addr = 19'd5; req0_data = 6'h01;
            clear_start = 1'b1; clear_color = 6'h0C;
            #1;
            check_eq("clr_go_ready0", req0_ready, 0);
            @(negedge clk);
            clear_start = 1'b0;
            check_eq("clr_busy", clear_busy, 1);
            for (int c = 0; c < FBW + 20; c++) begin
                if (req0_ready || req1_ready) bad++;
                @(negedge clk);
                if (fb_wen) begin
                    if (first_addr < 0) first_addr = int'(fb_addr);
                    if (fb_addr != 19'(nwr) || fb_din != 6'h0C) bad++;
                    nwr++;
                end
                if (!clear_busy && nwr == FBW) break;
            end
            check_eq("clr_first_addr", first_addr, 0);
            check_eq("clr_writes", nwr, FBW);
            check_eq("clr_bad", bad, 0);
            check_eq("clr_busy_done", clear_busy, 0);
            #1;
            check_eq("clr_after_ready0", req0_ready, 1);
            @(negedge clk);
            req0_valid = 1'b0;
            check_eq("clr_after_addr", fb_addr, 5);

            clear_start = 1'b1; clear_color = 6'h15;
            @(negedge clk);
            clear_start = 1'b0;
            for (int c = 0; c < 1100; c++) begin
                @(negedge clk);
                if (fb_wen && fb_addr == 19'd1000) begin
                    found = 1;
                    break;
                end
            end
            check_eq("abort_reach_1000", found, 1);
            #2 reset_n = 1'b0;
            #1;
            check_eq("abort_wen", fb_wen, 0);
            check_eq("abort_busy", clear_busy, 0);
            @(negedge clk);
            reset_n = 1'b1;
            nwr = 0;
            repeat (20) begin
                @(negedge clk);
                if (fb_wen || clear_busy) nwr++;
            end
            check_eq("abort_no_writes", nwr, 0);
        end
`else
        req0_valid  = 1'b1; req0_addr = 19'd7; req0_data = 6'h09;
        clear_start = 1'b1; clear_color = 6'h0C;
        #1;
        check_eq("noclr_ready0", req0_ready, 1);
        @(negedge clk);
        clear_start = 1'b0; req0_valid = 1'b0;
        check_eq("noclr_busy", clear_busy, 0);
        check_eq("noclr_addr", fb_addr, 7);
        check_eq("noclr_din", fb_din, 6'h09);
`endif

        // Asynchronous reset mid-cycle, then arbitration restarts at req0.
        req0_valid = 1'b1; req0_addr = 19'd33; req0_data = 6'h2A;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_wen", fb_wen, 0);
        check_eq("arst_addr", fb_addr, 0);
        check_eq("arst_drop", drop_count, 0);
        check_eq("arst_ready0", req0_ready, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        req1_valid = 1'b1; req1_addr = 19'd44; req1_data = 6'h11;
        #1;
        check_eq("post_rst_ready0", req0_ready, 1);
        check_eq("post_rst_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("post_rst_wen", fb_wen, 1);
        check_eq("post_rst_addr", fb_addr, 33);
        check_eq("post_rst_din", fb_din, 6'h2A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
